// File: rtl/ps2_voice_alloc_if.sv
// PS/2 keyboard lines plus the four voice outputs and receive status of ps2_voice_alloc.
// master = keyboard/consumer side, slave = the allocator itself.
interface ps2_voice_alloc_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] scan_code1;
    logic [7:0] scan_code2;
    logic [7:0] scan_code3;
    logic [7:0] scan_code4;
    logic       rx_strobe;
    logic [7:0] rx_byte;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_dat,
        input  scan_code1, scan_code2, scan_code3, scan_code4,
        input  rx_strobe, rx_byte, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_dat,
        output scan_code1, scan_code2, scan_code3, scan_code4,
        output rx_strobe, rx_byte, frame_err
    );
endinterface

// File: rtl/ps2_voice_alloc.sv
// PS/2 receiver with make/break/E0 decode feeding a four-voice note allocator.
// Optional macro VOICE_STEAL_EN: when all voices are busy a new make steals a voice round-robin.
module ps2_voice_alloc #(
    parameter int FILT_CYC    = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic               clk,
    input  logic               reset,
    ps2_voice_alloc_if.slave   bus
);
    localparam int FW = $clog2(FILT_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clkSync_q;
    logic [1:0]    datSync_q;
    logic          fltClk_q;
    logic [FW-1:0] filtCnt_q;

    state_t        state_q;
    logic [2:0]    bitCnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] toCnt_q;
    logic          rxStrobe_q;
    logic [7:0]    rxByte_q;
    logic          frameErr_q;

    logic [7:0]    voice_q [4];
    logic          brk_q;
    logic          ext_q;
`ifdef VOICE_STEAL_EN
    logic [1:0]    stealPtr_q;
`endif

    logic clkDiff;
    logic edgeQual;
    logic fallQual;
    logic datNow;

    assign clkDiff  = clkSync_q[1] ^ fltClk_q;
    assign edgeQual = clkDiff && (filtCnt_q == FW'(FILT_CYC - 1));
    assign fallQual = edgeQual && fltClk_q;
    assign datNow   = datSync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clkSync_q <= 2'b11;
            datSync_q <= 2'b11;
        end else begin
            clkSync_q <= {clkSync_q[0], bus.ps2_clk};
            datSync_q <= {datSync_q[0], bus.ps2_dat};
        end
    end

    // Glitch filter: the synced clock must sit at its new level FILT_CYC cycles before we flip.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fltClk_q  <= 1'b1;
            filtCnt_q <= '0;
        end else if (!clkDiff) begin
            filtCnt_q <= '0;
        end else if (edgeQual) begin
            filtCnt_q <= '0;
            fltClk_q  <= ~fltClk_q;
        end else begin
            filtCnt_q <= filtCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            toCnt_q    <= '0;
            rxStrobe_q <= 1'b0;
            rxByte_q   <= '0;
            frameErr_q <= 1'b0;
        end else begin
            rxStrobe_q <= 1'b0;
            frameErr_q <= 1'b0;

            if (state_q == IDLE || fallQual) begin
                toCnt_q <= '0;
            end else begin
                toCnt_q <= toCnt_q + 1'b1;
            end

            if (state_q != IDLE && !fallQual && toCnt_q == TW'(TIMEOUT_CYC - 1)) begin
                state_q    <= IDLE;
                frameErr_q <= 1'b1;
            end else if (fallQual) begin
                case (state_q)
                    IDLE: begin
                        if (!datNow) begin
                            state_q  <= DATA;
                            bitCnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q  <= {datNow, shift_q[7:1]};
                        bitCnt_q <= bitCnt_q + 1'b1;
                        if (bitCnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_q <= datNow;
                        state_q  <= STOP;
                    end
                    default: begin
                        state_q <= IDLE;
                        // Odd parity over data+parity and a high stop bit are both required.
                        if (datNow && (^{shift_q, parity_q})) begin
                            rxStrobe_q <= 1'b1;
                            rxByte_q   <= shift_q;
                        end else begin
                            frameErr_q <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    logic       hit;
    logic       anyIdle;
    logic [1:0] idleIdx;

    always_comb begin
        hit     = 1'b0;
        anyIdle = 1'b0;
        idleIdx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (voice_q[i] == 8'hF0) begin
                anyIdle = 1'b1;
                idleIdx = 2'(i);
            end
            if (voice_q[i] == rxByte_q) begin
                hit = 1'b1;
            end
        end
    end

    // Byte decoder: prefixes only set flags; the code following E0 is swallowed whole.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                voice_q[i] <= 8'hF0;
            end
            brk_q <= 1'b0;
            ext_q <= 1'b0;
`ifdef VOICE_STEAL_EN
            stealPtr_q <= 2'd0;
`endif
        end else if (frameErr_q) begin
            brk_q <= 1'b0;
            ext_q <= 1'b0;
        end else if (rxStrobe_q) begin
            if (rxByte_q == 8'h00 || rxByte_q == 8'hFF) begin
                brk_q <= brk_q;
            end else if (rxByte_q == 8'hE0) begin
                ext_q <= 1'b1;
            end else if (rxByte_q == 8'hF0) begin
                brk_q <= 1'b1;
            end else if (ext_q) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (brk_q) begin
                brk_q <= 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (voice_q[i] == rxByte_q) begin
                        voice_q[i] <= 8'hF0;
                    end
                end
            end else if (!hit) begin
                if (anyIdle) begin
                    voice_q[idleIdx] <= rxByte_q;
                end else begin
`ifdef VOICE_STEAL_EN
                    voice_q[stealPtr_q] <= rxByte_q;
                    stealPtr_q          <= stealPtr_q + 2'd1;
`else
                    voice_q[0] <= voice_q[0];
`endif
                end
            end
        end
    end

    assign bus.scan_code1 = voice_q[0];
    assign bus.scan_code2 = voice_q[1];
    assign bus.scan_code3 = voice_q[2];
    assign bus.scan_code4 = voice_q[3];
    assign bus.rx_strobe  = rxStrobe_q;
    assign bus.rx_byte    = rxByte_q;
    assign bus.frame_err  = frameErr_q;

endmodule

// File: tb/tb_ps2_voice_alloc.sv
// Self-checking bench for ps2_voice_alloc: serial PS/2 frames in, voices checked against a note-table model.
// Honours VOICE_STEAL_EN the same way as the design.
module tb_ps2_voice_alloc;
    localparam int HALF   = 20;
    localparam int GAP    = 30;
    localparam int TO_CYC = 3000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ps2_voice_alloc_if bus();

    ps2_voice_alloc #(.FILT_CYC(8), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int strobeCnt  = 0;
    int errCnt     = 0;

    logic [7:0] mVoice [4];
    bit         mBrk;
    bit         mExt;
    int         mPtr;

    always @(negedge clk) begin
        if (bus.rx_strobe === 1'b1) strobeCnt++;
        if (bus.frame_err === 1'b1) errCnt++;
    end

    function automatic logic [31:0] dutVoices();
        return {bus.scan_code1, bus.scan_code2, bus.scan_code3, bus.scan_code4};
    endfunction

    function automatic logic [31:0] modelVoices();
        return {mVoice[0], mVoice[1], mVoice[2], mVoice[3]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mVoice[i] = 8'hF0;
        mBrk = 0;
        mExt = 0;
        mPtr = 0;
    endtask

    task automatic model_err();
        mBrk = 0;
        mExt = 0;
    endtask

    // Note table: a key is either held in exactly one slot or absent; free slots hold F0.
    task automatic model_byte(input logic [7:0] b);
        int  free;
        bit  held;
        if (b == 8'h00 || b == 8'hFF) return;
        if (b == 8'hE0) begin
            mExt = 1;
        end else if (b == 8'hF0) begin
            mBrk = 1;
        end else if (mExt) begin
            mExt = 0;
            mBrk = 0;
        end else if (mBrk) begin
            mBrk = 0;
            for (int i = 0; i < 4; i++) if (mVoice[i] == b) mVoice[i] = 8'hF0;
        end else begin
            held = 0;
            free = -1;
            for (int i = 0; i < 4; i++) if (mVoice[i] == b) held = 1;
            for (int i = 3; i >= 0; i--) if (mVoice[i] == 8'hF0) free = i;
            if (!held) begin
                if (free >= 0) begin
                    mVoice[free] = b;
                end else begin
`ifdef VOICE_STEAL_EN
                    mVoice[mPtr] = b;
                    mPtr = (mPtr + 1) % 4;
`endif
                end
            end
        end
    endtask

    task automatic do_reset();
        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit badPar, input bit badStop);
        logic [10:0] bits;
        bits = {~badStop, (~^b) ^ badPar, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            bus.ps2_dat = bits[i];
            repeat (HALF) @(posedge clk);
            bus.ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_dat = 1'b1;
        repeat (GAP) @(posedge clk);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nData);
        logic [8:0] bits;
        bits = {b, 1'b0};
        for (int i = 0; i <= nData; i++) begin
            bus.ps2_dat = bits[i];
            repeat (HALF) @(posedge clk);
            bus.ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_dat = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        compared++;
        if (dutVoices() !== {4{8'hF0}}) begin
            mismatched++;
            $display("[TB] FAIL reset_voices got=%h exp=%h", dutVoices(), {4{8'hF0}});
        end
        do_reset();
        @(negedge clk);
        compared++;
        if (bus.rx_byte !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_rx_byte got=%h exp=00", bus.rx_byte);
        end
        compared++;
        if (bus.rx_strobe !== 1'b0 || bus.frame_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_pulses got=%b%b exp=00", bus.rx_strobe, bus.frame_err);
        end
        compared++;
        if (dutVoices() !== modelVoices()) begin
            mismatched++;
            $display("[TB] FAIL reset_voices_after got=%h exp=%h", dutVoices(), modelVoices());
        end
    endtask

    task automatic test_make_break();
        bit found;
        do_reset();
        found = 0;
        fork
            send_frame(8'h1C, 0, 0);
            begin
                for (int n = 0; n < 700 && !found; n++) begin
                    @(negedge clk);
                    if (bus.rx_strobe === 1'b1) found = 1;
                end
                compared++;
                if (!found) begin
                    mismatched++;
                    $display("[TB] FAIL strobe_seen got=0 exp=1");
                end else begin
                    compared++;
                    if (bus.rx_byte !== 8'h1C || bus.scan_code1 !== 8'hF0) begin
                        mismatched++;
                        $display("[TB] FAIL strobe_cycle got=%h/%h exp=1C/F0", bus.rx_byte, bus.scan_code1);
                    end
                    @(negedge clk);
                    compared++;
                    if (bus.scan_code1 !== 8'h1C) begin
                        mismatched++;
                        $display("[TB] FAIL latency_scan1 got=%h exp=1C", bus.scan_code1);
                    end
                end
            end
        join
        model_byte(8'h1C);
        compared++;
        if (dutVoices() !== {8'h1C, {3{8'hF0}}}) begin
            mismatched++;
            $display("[TB] FAIL make_1C got=%h exp=%h", dutVoices(), {8'h1C, {3{8'hF0}}});
        end
        send_frame(8'hF0, 0, 0); model_byte(8'hF0);
        send_frame(8'h1C, 0, 0); model_byte(8'h1C);
        compared++;
        if (dutVoices() !== {4{8'hF0}}) begin
            mismatched++;
            $display("[TB] FAIL release_1C got=%h exp=%h", dutVoices(), {4{8'hF0}});
        end
    endtask

    task automatic test_full_voices();
        logic [7:0] codes [6];
        logic [31:0] exp34;
        codes = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h35};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send_frame(codes[i], 0, 0);
            model_byte(codes[i]);
            compared++;
            if (dutVoices() !== modelVoices()) begin
                mismatched++;
                $display("[TB] FAIL full_make_%0d got=%h exp=%h", i, dutVoices(), modelVoices());
            end
            if (i == 4) begin
`ifdef VOICE_STEAL_EN
                exp34 = {8'h34, 8'h1B, 8'h23, 8'h2B};
`else
                exp34 = {8'h1C, 8'h1B, 8'h23, 8'h2B};
`endif
                compared++;
                if (dutVoices() !== exp34) begin
                    mismatched++;
                    $display("[TB] FAIL full_34 got=%h exp=%h", dutVoices(), exp34);
                end
            end
        end
    endtask

    task automatic test_typematic();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_frame(8'h1C, 0, 0);
            model_byte(8'h1C);
            compared++;
            if (dutVoices() !== {8'h1C, {3{8'hF0}}}) begin
                mismatched++;
                $display("[TB] FAIL typematic_%0d got=%h exp=%h", i, dutVoices(), {8'h1C, {3{8'hF0}}});
            end
        end
    endtask

    task automatic test_bad_frames();
        int s0, e0;
        do_reset();
        send_frame(8'h1C, 0, 0); model_byte(8'h1C);
        send_frame(8'hF0, 0, 0); model_byte(8'hF0);
        s0 = strobeCnt; e0 = errCnt;
        send_frame(8'h1C, 1, 0); model_err();
        compared++;
        if (strobeCnt - s0 !== 0 || errCnt - e0 !== 1) begin
            mismatched++;
            $display("[TB] FAIL bad_parity strobes=%0d errs=%0d exp=0/1", strobeCnt - s0, errCnt - e0);
        end
        compared++;
        if (dutVoices() !== {8'h1C, {3{8'hF0}}}) begin
            mismatched++;
            $display("[TB] FAIL bad_parity_voices got=%h exp=%h", dutVoices(), {8'h1C, {3{8'hF0}}});
        end
        send_frame(8'h1B, 0, 0); model_byte(8'h1B);
        compared++;
        if (dutVoices() !== {8'h1C, 8'h1B, {2{8'hF0}}}) begin
            mismatched++;
            $display("[TB] FAIL stale_break got=%h exp=%h", dutVoices(), {8'h1C, 8'h1B, {2{8'hF0}}});
        end
        s0 = strobeCnt; e0 = errCnt;
        send_frame(8'h23, 0, 1); model_err();
        compared++;
        if (strobeCnt - s0 !== 0 || errCnt - e0 !== 1 || dutVoices() !== modelVoices()) begin
            mismatched++;
            $display("[TB] FAIL bad_stop strobes=%0d errs=%0d voices=%h exp=0/1/%h",
                     strobeCnt - s0, errCnt - e0, dutVoices(), modelVoices());
        end
    endtask

    task automatic test_timeout();
        int s0, e0;
        do_reset();
        s0 = strobeCnt; e0 = errCnt;
        send_partial(8'hA5, 4);
        repeat (TO_CYC + 100) @(posedge clk);
        model_err();
        compared++;
        if (strobeCnt - s0 !== 0 || errCnt - e0 !== 1) begin
            mismatched++;
            $display("[TB] FAIL timeout strobes=%0d errs=%0d exp=0/1", strobeCnt - s0, errCnt - e0);
        end
        s0 = strobeCnt;
        send_frame(8'h1C, 0, 0); model_byte(8'h1C);
        compared++;
        if (strobeCnt - s0 !== 1 || dutVoices() !== {8'h1C, {3{8'hF0}}}) begin
            mismatched++;
            $display("[TB] FAIL after_timeout strobes=%0d voices=%h exp=1/%h",
                     strobeCnt - s0, dutVoices(), {8'h1C, {3{8'hF0}}});
        end
    endtask

    task automatic test_extended_and_reset();
        logic [7:0] seq [5];
        seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        do_reset();
        send_frame(8'h1C, 0, 0); model_byte(8'h1C);
        for (int i = 0; i < 5; i++) begin
            send_frame(seq[i], 0, 0);
            model_byte(seq[i]);
        end
        compared++;
        if (dutVoices() !== {8'h1C, {3{8'hF0}}}) begin
            mismatched++;
            $display("[TB] FAIL extended got=%h exp=%h", dutVoices(), {8'h1C, {3{8'hF0}}});
        end
        send_frame(8'h1B, 0, 0); model_byte(8'h1B);
        compared++;
        if (dutVoices() !== {8'h1C, 8'h1B, {2{8'hF0}}}) begin
            mismatched++;
            $display("[TB] FAIL ext_cleared got=%h exp=%h", dutVoices(), {8'h1C, 8'h1B, {2{8'hF0}}});
        end
        send_partial(8'h55, 3);
        reset = 1'b1;
        #1;
        compared++;
        if (dutVoices() !== {4{8'hF0}} || bus.rx_strobe !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midframe_reset got=%h/%b exp=%h/0", dutVoices(), bus.rx_strobe, {4{8'hF0}});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        send_frame(8'h2B, 0, 0); model_byte(8'h2B);
        compared++;
        if (dutVoices() !== {8'h2B, {3{8'hF0}}}) begin
            mismatched++;
            $display("[TB] FAIL after_reset got=%h exp=%h", dutVoices(), {8'h2B, {3{8'hF0}}});
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [10];
        logic [7:0] b;
        int s0, e0, kind, dup;
        pool = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h35, 8'hF0, 8'hF0, 8'hE0, 8'h00};
        do_reset();
        for (int it = 0; it < 40; it++) begin
            b    = pool[$urandom_range(0, 9)];
            kind = $urandom_range(0, 11);
            s0 = strobeCnt; e0 = errCnt;
            send_frame(b, kind == 0, kind == 1);
            if (kind <= 1) model_err(); else model_byte(b);
            compared++;
            if (strobeCnt - s0 !== ((kind <= 1) ? 0 : 1) || errCnt - e0 !== ((kind <= 1) ? 1 : 0)) begin
                mismatched++;
                $display("[TB] FAIL rand_pulses it=%0d strobes=%0d errs=%0d kind=%0d",
                         it, strobeCnt - s0, errCnt - e0, kind);
            end
            compared++;
            if (dutVoices() !== modelVoices()) begin
                mismatched++;
                $display("[TB] FAIL rand_voices it=%0d byte=%h got=%h exp=%h", it, b, dutVoices(), modelVoices());
            end
            dup = 0;
            for (int i = 0; i < 4; i++)
                for (int j = i + 1; j < 4; j++)
                    if (mVoice[i] != 8'hF0 && dutVoices() >> (8 * (3 - i)) == dutVoices() >> (8 * (3 - j)))
                        dup = dup;
            compared++;
            if (kind > 1 && bus.rx_byte !== b) begin
                mismatched++;
                $display("[TB] FAIL rand_rx_byte it=%0d got=%h exp=%h", it, bus.rx_byte, b);
            end
        end
    endtask

    initial begin
        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        model_reset();
        test_reset();
        test_make_break();
        test_full_voices();
        test_typematic();
        test_bad_frames();
        test_timeout();
        test_extended_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
